// File: rtl/req_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : req_enc_pkg
// Description : Shared types and helpers for the 32-to-5 request encoder.
//               Provides the default sizes, the FSM state type, the vector and
//               index typedefs, and a one-hot decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package req_enc_pkg;

  localparam int N_REQ_DEF = 32;
  localparam int IDX_W_DEF = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  typedef logic [N_REQ_DEF-1:0] req_vec_t;
  typedef logic [IDX_W_DEF-1:0] idx_t;

  // One-hot decode of an index: the mirror of the datapath select decoder.
  function automatic req_vec_t onehot(input idx_t idx);
    req_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage : req_enc_pkg
`default_nettype wire

// File: rtl/req_encoder_32to5_prio_enc32.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc32
// Description : Combinational descending priority encoder with a movable
//               start point. The search examines vec[start] first, then
//               start-1, ... wrapping from 0 to N_REQ-1. With start tied to
//               N_REQ-1 it is a plain highest-index-wins encoder.
// Ports       : vec   - candidate vector
//               start - first index examined
//               idx   - first set index found (0 when none)
//               found - vec has at least one set bit
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc32 #(
  parameter  int N_REQ = 32,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] w_cand;

  // Walk from the lowest priority position up to the highest so the last
  // hit written is the winner. Index arithmetic wraps naturally because
  // N_REQ is a power of two.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    w_cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = start - IDX_W'(k);
      if (vec[w_cand]) begin
        idx   = w_cand;
        found = 1'b1;
      end
    end
  end

endmodule : prio_enc32
`default_nettype wire

// File: rtl/req_encoder_32to5.sv
`default_nettype none
// ============================================================================
// Module      : req_encoder_32to5
// Description : Sequential 32-to-5 request encoder. Request lines are OR'd
//               into a pending register; one pending source is encoded and
//               offered on a valid/ready handshake, and its pending bit is
//               retired when the consumer accepts. One IDLE bubble per grant.
// Build macro : REQ_ENC_ROUND_ROBIN_EN - when defined, the encoder searches
//               downward from just below the last retired index (with wrap)
//               instead of fixed highest-index-first priority.
// Ports       : clk         - clock, rising edge
//               rst_n       - asynchronous active-low reset
//               req         - request lines, OR'd into pending each edge
//               clr_all     - synchronous flush of pending and any offer
//               out_valid   - out_idx holds a pending source
//               out_idx     - encoded source index
//               out_ready   - consumer accept (with out_valid)
//               pending     - registered pending vector
//               any_pending - registered |pending
// Revision    : 1.0 - initial release
// ============================================================================
module req_encoder_32to5
  import req_enc_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             clr_all,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic [N_REQ-1:0] pending,
  output logic             any_pending
);

  state_t           r_state;
  logic             w_retire;
  req_vec_t         w_onehot;
  logic [N_REQ-1:0] w_retire_mask;
  logic [N_REQ-1:0] w_pending_nxt;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_enc_idx;
  logic             w_enc_found;

  // out_valid is high exactly while an offer is outstanding.
  assign out_valid = (r_state == OFFER);

  // A flush cancels the accept: nothing is retired and rr_ptr is untouched.
  assign w_retire      = out_valid && out_ready && !clr_all;
  assign w_onehot      = onehot(idx_t'(out_idx));
  assign w_retire_mask = w_retire ? w_onehot[N_REQ-1:0] : '0;

  // A request on the bit being retired wins, so it stays pending.
  assign w_pending_nxt = clr_all ? '0 : ((pending & ~w_retire_mask) | req);

`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '1;
    end else if (w_retire) begin
      r_rr_ptr <= out_idx;
    end
  end

  // Search begins one below the last retired index.
  assign w_start = r_rr_ptr - 1'b1;
`else
  assign w_start = '1;
`endif

  prio_enc32 #(
    .N_REQ (N_REQ)
  ) u_prio_enc (
    .vec   (pending),
    .start (w_start),
    .idx   (w_enc_idx),
    .found (w_enc_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      any_pending <= 1'b0;
    end else begin
      pending     <= w_pending_nxt;
      any_pending <= |w_pending_nxt;
    end
  end

  // out_idx only loads on IDLE->OFFER, so it stays frozen through the offer
  // and keeps its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      out_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!clr_all && w_enc_found) begin
            r_state <= OFFER;
            out_idx <= w_enc_idx;
          end
        end
        OFFER: begin
          if (clr_all || out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : req_encoder_32to5
`default_nettype wire

// File: tb/tb_req_encoder_32to5.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_encoder_32to5
// Description : Self-checking bench for req_encoder_32to5. A cycle-level
//               reference model built from the pending/grant rules is
//               compared against the DUT after every clock, with directed
//               scenarios followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_req_encoder_32to5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req = '0;
  logic        clr_all = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic [31:0] pending;
  logic        any_pending;

  req_encoder_32to5 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .clr_all     (clr_all),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .out_ready   (out_ready),
    .pending     (pending),
    .any_pending (any_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int grants[$];

  // reference model state
  logic [31:0] m_pend;
  bit          m_valid;
  int          m_idx;
  int          m_rr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // First set index when scanning downward from 'first' with wrap.
  function automatic int ref_encode(input logic [31:0] v, input int first);
    for (int k = 0; k < 32; k++) begin
      int i;
      i = (first - k + 64) % 32;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 0;
    m_idx   = 0;
    m_rr    = 31;
  endtask

  task automatic model_step();
    logic [31:0] np;
    int          first;
    np = m_pend;
    if (clr_all) begin
      np      = '0;
      m_valid = 0;
    end else if (m_valid) begin
      if (out_ready) begin
        np[m_idx] = 1'b0;
        m_valid   = 0;
        m_rr      = m_idx;
      end
      np = np | req;
    end else begin
      if (m_pend != 0) begin
`ifdef REQ_ENC_ROUND_ROBIN_EN
        first = (m_rr + 31) % 32;
`else
        first = 31;
`endif
        m_idx   = ref_encode(m_pend, first);
        m_valid = 1;
      end
      np = np | req;
    end
    m_pend = np;
  endtask

  task automatic check_outputs();
    chk("valid", out_valid, m_valid);
    chk("idx", out_idx, m_idx);
    chk("pend", pending, m_pend);
    chk("anyp", any_pending, m_pend != 0);
  endtask

  task automatic cycle();
    if (rst_n && out_valid && out_ready && !clr_all) grants.push_back(int'(out_idx));
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; clr_all = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
    check_outputs();
  endtask

  task automatic wait_offer();
    for (int i = 0; i < 20 && !out_valid; i++) cycle();
    chk("offer_seen", out_valid, 1);
  endtask

  task automatic check_grants(input string tag, input int exp[$]);
    chk({tag, "_count"}, grants.size(), exp.size());
    for (int i = 0; i < exp.size() && i < grants.size(); i++)
      chk(tag, grants[i], exp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q[$];

    // ---- reset, single low request
    do_reset();
    req = 32'h0000_0001;
    cycle();
    req = '0;
    cycle();
    chk("t1_valid", out_valid, 1);
    chk("t1_idx", out_idx, 0);
    out_ready = 1'b1;
    cycle();
    chk("t1_valid_low", out_valid, 0);
    chk("t1_pend", pending, 0);

    // ---- two sources, highest granted first
    grants.delete();
    req = 32'h8000_0010;
    cycle();
    req = '0;
    repeat (6) cycle();
    exp_q = '{31, 4};
    check_grants("t2_grants", exp_q);
    chk("t2_anyp", any_pending, 0);

    // ---- frozen offer while a new request arrives
    grants.delete();
    out_ready = 1'b0;
    req = 32'h0000_0010;
    cycle();
    req = '0;
    wait_offer();
    repeat (5) cycle();
    req = 32'h0010_0000;
    cycle();
    req = '0;
    repeat (3) begin
      cycle();
      chk("t3_frozen", out_idx, 4);
    end
    out_ready = 1'b1;
    repeat (6) cycle();
    exp_q = '{4, 20};
    check_grants("t3_grants", exp_q);

    // ---- retire and re-request the same bit in one cycle
    grants.delete();
    out_ready = 1'b0;
    req = 32'h0000_0080;
    cycle();
    req = '0;
    wait_offer();
    chk("t4_idx", out_idx, 7);
    out_ready = 1'b1;
    req = 32'h0000_0080;
    cycle();
    chk("t4_pend7", pending[7], 1);
    req = '0;
    repeat (3) cycle();
    exp_q = '{7, 7};
    check_grants("t4_grants", exp_q);
    chk("t4_pend_empty", pending, 0);

    // ---- flush during an offer beats accept and requests
    grants.delete();
    out_ready = 1'b0;
    req = 32'h0000_0008;
    cycle();
    req = '0;
    wait_offer();
    clr_all = 1'b1;
    out_ready = 1'b1;
    req = 32'hFFFF_FFFF;
    cycle();
    chk("t5_pend", pending, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_no_retire", grants.size(), 0);
    clr_all = 1'b0;
    req = '0;
    out_ready = 1'b0;
    cycle();

    // ---- held requests: grant order depends on the build
    do_reset();
    grants.delete();
    req = 32'h0000_0111;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && grants.size() < 6; i++) cycle();
`ifdef REQ_ENC_ROUND_ROBIN_EN
    exp_q = '{8, 4, 0, 8, 4, 0};
`else
    exp_q = '{8, 8, 8, 8, 8, 8};
`endif
    check_grants("t6_grants", exp_q);
    req = '0;
    repeat (8) cycle();

    // ---- asynchronous reset in the middle of an offer
    out_ready = 1'b0;
    req = 32'h0000_0200;
    cycle();
    req = '0;
    wait_offer();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t7_valid", out_valid, 0);
    chk("t7_pend", pending, 0);
    chk("t7_anyp", any_pending, 0);
    chk("t7_idx", out_idx, 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    cycle();

    // ---- randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: req = $urandom;
        1: req = 32'h1 << $urandom_range(0, 31);
        default: req = '0;
      endcase
      out_ready = 1'($urandom_range(0, 1));
      clr_all   = ($urandom_range(0, 31) == 0);
      cycle();
    end
    req = '0; clr_all = 1'b0; out_ready = 1'b1;
    repeat (80) cycle();
    chk("drain_anyp", any_pending, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_req_encoder_32to5
`default_nettype wire

// File: doc/req_encoder_32to5.md
Name: req_encoder_32to5

Overview:
- Sequential 32-to-5 request encoder; the inverse of the datapath's 5-to-32 select decoder.
- Collects request lines from up to 32 sources into a pending register and encodes one pending source to a 5-bit index.
- Offers that index on a valid/ready handshake and retires the bit when the consumer accepts it.
- Feeds bus-source/register-select encoding and interrupt/exception source numbering into the control unit.

Parameters:
- N_REQ, 32, number of request lines; must be a power of two, 2..32.
- IDX_W, $clog2(N_REQ) = 5, index width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  request lines, sampled each edge, OR'd into pending (level or pulse both legal).
- clr_all  input  1  synchronous flush of all pending and any in-flight offer.
- out_valid  output  1  out_idx holds a pending source.
- out_idx  output  IDX_W  encoded source index.
- out_ready  input  1  consumer accepts out_idx when out_valid && out_ready.
- pending  output  N_REQ  registered pending vector, status only.
- any_pending  output  1  |pending, registered.

Behaviour:
- Reset (rst_n low, async): pending=0, out_valid=0, out_idx=0, any_pending=0, FSM=IDLE, rr_ptr=N_REQ-1. Deassertion is synchronous to clk (external synchroniser).
- pending next = clr_all ? 0 : (pending & ~retire_mask) | req.
- retire_mask is one-hot(out_idx) when out_valid && out_ready, else 0.
- req set on the bit being retired in the same cycle: req wins, bit stays pending.
- FSM IDLE:
  - pending != 0 and !clr_all -> OFFER.
  - out_idx <= encode(pending); out_valid <= 1.
- FSM OFFER:
  - out_idx is frozen while out_valid=1, even if higher-priority requests arrive.
  - out_ready=1 -> retire bit out_idx, out_valid <= 0, -> IDLE.
  - out_ready=0 -> stay, hold out_valid=1 and out_idx.
- Latency:
  - req at edge N sets pending at N.
  - IDLE evaluates at N+1, so out_valid is high after edge N+1.
  - A minimum of 2 cycles per grant (one IDLE bubble); throughput is not a goal.
- encode() default is fixed priority: highest set index wins (bit 31 > bit 0), matching the decoder's Y31 ordering.
- clr_all: in any state, pending=0, out_valid=0, FSM=IDLE next edge. clr_all overrides req and out_ready in the same cycle.
- out_ready while out_valid=0: ignored.
- A source that stays asserted continuously is re-pended every cycle and re-granted after each retire. Under fixed priority it starves lower sources by design.
- Reset mid-OFFER: immediate return to reset values; no retire occurs.
- out_idx changes only on an IDLE->OFFER edge or on reset; in IDLE it holds its last value.

Optional Feature:
- Macro: REQ_ENC_ROUND_ROBIN_EN.
- Defined:
  - encode() searches pending starting at rr_ptr-1 and descends with wrap (0 -> N_REQ-1).
  - rr_ptr <= out_idx on each retire; rr_ptr is reset to N_REQ-1.
  - First grant after reset is therefore the highest set index at or below N_REQ-2, then wraps to N_REQ-1.
- Undefined: rr_ptr does not exist and fixed priority applies.
- Ports and handshake are identical in both builds.

Decomposition:
- Shared package req_enc_pkg holds:
  - constants N_REQ_DEF=32 and IDX_W_DEF=5;
  - typedef state_t {IDLE, OFFER};
  - typedefs req_vec_t and idx_t;
  - function onehot(idx).
- Natural sub-module: prio_enc32 is purely combinational. It takes vector and start pointer, and outputs idx and found. It is used with start pointer tied to N_REQ-1 when the feature is disabled.

Test Plan:
- Reset then req=0x0000_0001 for one cycle -> out_valid high 2 edges later, out_idx=0. With out_ready=1 -> pending=0 and out_valid low next cycle.
- req=0x8000_0010 pulsed, out_ready=1 -> grants 31 then 4, each accepted; any_pending=0 afterwards.
- Offer idx=4 with out_ready=0 for 5 cycles, then req bit 20 arrives -> out_idx stays 4 until accepted; next grant is 20.
- Same cycle: retire idx 7 and req bit 7 -> pending[7] remains 1; idx 7 is offered again.
- clr_all during OFFER with out_ready=1 and req=0xFFFF_FFFF -> pending=0, out_valid=0, no retire.
- With REQ_ENC_ROUND_ROBIN_EN and req held 0x0000_0111 -> grant sequence 8,4,0,8,4,0. Without the macro -> 8,8,8.
- Async: drop rst_n mid-OFFER between edges -> out_valid and pending are 0 immediately.
